regfile_lvt: RTL and testbench
==============================

# regfile_lvt

Parametrised multi-write, multi-read register file for the out-of-order core. It generalises the fixed 2-write/8-read 64-bit register file to NWR write ports and NRD read ports, using replicated banks plus a live-value table (LVT). Reads are registered and write-first bypassed, and write conflicts have fixed priority. A reset-triggered clear sweep zeroes every entry. It sits between the rename/issue stage (read addresses) and the writeback/commit stage (write ports).

## Interface
- WID, 64, data width in bits
- AWID, 6, address width; DEPTH = 2**AWID entries
- NWR, 2, number of write ports (1..4)
- NRD, 8, number of read ports (1..8)
- ZERO_R0, 1, when 1 address 0 always reads 0 and writes to it are dropped
- clk  in  1  the single clock; all state changes on the rising edge
- rst  in  1  reset, synchronous and active-high; starts the clear sweep
- wr  in  NWR  write enable per port
- wa  in  NWR*AWID  write addresses, port k at [k*AWID +: AWID]
- i  in  NWR*WID  write data, port k at [k*WID +: WID]
- ra  in  NRD*AWID  read addresses, port j at [j*AWID +: AWID]
- o  out  NRD*WID  read data, port j at [j*WID +: WID]; registered
- busy  out  1  high while the clear sweep runs; writes are ignored while high

## Operation
- Storage is NWR×NRD bank memories. Bank (k,j) is written only by write port k and read only by read port j.
- LVT has DEPTH entries of ceil(log2 NWR) bits, with a minimum of 1. It records the last write port to write each address. Read port j selects bank (LVT[ra_j], j).
- Write conflict: if several ports write the same address in one cycle, the highest port index wins. Only that port updates the LVT; lower ports' bank writes are harmless.
- Bypass (write-first): a read sampled on the same edge as a write to the same address returns the new data, using the same highest-index priority.
- ZERO_R0=1: writes to address 0 are suppressed in the banks, the LVT and the bypass, and the output for ra=0 is forced to 0.
- FSM states:
  - CLEAR: entered on any edge with rst=1.
    - A counter cnt is loaded with 0 on that edge.
    - On each following edge in CLEAR, the block writes 0 to bank (0,*)[cnt] and 0 to LVT[cnt], then increments cnt.
    - The move to RUN happens on the edge that clears cnt=DEPTH-1.
  - RUN: normal operation.
- In CLEAR, wr is ignored and all o are driven to 0.
- rst asserted mid-sweep restarts cnt at 0.
- rst in RUN re-enters CLEAR; contents are then lost.

## Timing
- Reset values, on the edge with rst=1:
  - o = 0, busy = 1, state = CLEAR, cnt = 0.
- Clear duration: busy stays 1 for DEPTH cycles after the rst edge. For DEPTH=64, busy falls on the 64th edge after rst is deasserted.
- Read latency is 1. ra sampled at edge N gives o valid from just after edge N until edge N+1.
- Write latency is 1. A write at edge N is visible:
  - at edge N through the bypass;
  - at edge N+1 and later through the banks and LVT.
- o holds its last value only until the next edge. There is no read enable, so every edge samples ra.
- There is no backpressure: a write accepted in RUN always completes in one cycle.

## Test plan
- Reset/clear: preload garbage, pulse rst for 1 cycle -> busy=1 for exactly 64 cycles; afterwards every address on all 8 ports reads 0.
- Basic write/read: port0 writes 0xDEAD_BEEF_0000_0001 to addr 5; next cycle ra0..7=5 -> all o = 0xDEAD_BEEF_0000_0001 after one edge.
- Conflict: same edge, port0 writes 0x11 to addr 9 and port1 writes 0x22 to addr 9 -> subsequent reads of 9 return 0x22. Then port0 alone writes 0x33 to addr 9 -> reads return 0x33 (LVT switched back).
- Bypass: write 0x77 to addr 12 and read addr 12 on the same edge -> o = 0x77 immediately after that edge. A simultaneous read of addr 13 returns its old value.
- R0: write 0xFF to addr 0 -> reads of addr 0 return 0, on the same edge and later.
- Reset mid-sweep: assert rst at clear cycle 30 -> busy stays high for 64 cycles from the new rst edge. Writes issued during busy are lost (the target address reads 0 afterwards).

Source files
------------

// File: rtl/regfile_lvt.sv
// Multi-write, multi-read register file built from NWR x NRD replicated banks and a
// live-value table; registered write-first reads and a reset-started clear sweep.
module regfile_lvt #(
    parameter int WID     = 64,
    parameter int AWID    = 6,
    parameter int NWR     = 2,
    parameter int NRD     = 8,
    parameter int ZERO_R0 = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      wr,
    input  logic [NWR*AWID-1:0] wa,
    input  logic [NWR*WID-1:0]  i,
    input  logic [NRD*AWID-1:0] ra,
    output logic [NRD*WID-1:0]  o,
    output logic                busy
);
    localparam int DEPTH = 2 ** AWID;
    localparam int LW    = (NWR > 1) ? $clog2(NWR) : 1;

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [AWID-1:0]         cnt_q, cnt_d;
    logic [NRD*WID-1:0]      o_q, o_d;

    logic [WID-1:0]          bank_q [NWR][NRD][DEPTH];
    logic [LW-1:0]           lvt_q  [DEPTH];

    logic [NWR-1:0]          we;
    logic [AWID-1:0]         wa_k   [NWR];
    logic [WID-1:0]          wd_k   [NWR];
    logic                    clr_en;

    // Effective write enables: only in RUN, and address 0 is dropped when hardwired.
    always_comb begin
        clr_en = (state_q == CLEAR) && !rst;
        for (int k = 0; k < NWR; k++) begin
            wa_k[k] = wa[k*AWID +: AWID];
            wd_k[k] = i[k*WID +: WID];
            we[k]   = (state_q == RUN) && !rst && wr[k] &&
                      !((ZERO_R0 != 0) && (wa_k[k] == '0));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Each write port owns one bank per read port; the sweep reuses port 0's banks.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NWR; k++) begin
            for (int j = 0; j < NRD; j++) begin
                if (we[k]) begin
                    bank_q[k][j][wa_k[k]] <= wd_k[k];
                end
            end
        end
        if (clr_en) begin
            for (int j = 0; j < NRD; j++) begin
                bank_q[0][j][cnt_q] <= '0;
            end
        end
    end

    // Ascending loop: on an address conflict the last (highest) port's update lands.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NWR; k++) begin
            if (we[k]) begin
                lvt_q[wa_k[k]] <= LW'(k);
            end
        end
        if (clr_en) begin
            lvt_q[cnt_q] <= '0;
        end
    end

    always_comb begin
        logic [AWID-1:0] ra_j;
        logic [LW-1:0]   sel;
        logic [WID-1:0]  rd;
        o_d  = '0;
        ra_j = '0;
        sel  = '0;
        rd   = '0;
        for (int j = 0; j < NRD; j++) begin
            ra_j = ra[j*AWID +: AWID];
            sel  = lvt_q[ra_j];
            rd   = '0;
            if (int'(sel) < NWR) begin
                rd = bank_q[sel][j][ra_j];
            end
            // Write-first bypass; later (higher) ports override earlier ones.
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && (wa_k[k] == ra_j)) begin
                    rd = wd_k[k];
                end
            end
            if (((ZERO_R0 != 0) && (ra_j == '0)) || (state_q != RUN)) begin
                rd = '0;
            end
            o_d[j*WID +: WID] = rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= '0;
        end else begin
            o_q <= o_d;
        end
    end

    assign o    = o_q;
    assign busy = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_lvt.sv
// Scoreboard bench for regfile_lvt: a flat-memory model predicts busy and every
// read port per edge; a monitor pops and compares one edge after each stimulus.
module tb_regfile_lvt;
    localparam int WID   = 64;
    localparam int AWID  = 6;
    localparam int NWR   = 2;
    localparam int NRD   = 8;
    localparam int DEPTH = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic [NWR-1:0]      wr;
    logic [NWR*AWID-1:0] wa;
    logic [NWR*WID-1:0]  i;
    logic [NRD*AWID-1:0] ra;
    logic [NRD*WID-1:0]  o;
    logic                busy;

    always #5 clk = ~clk;

    regfile_lvt #(.WID(WID), .AWID(AWID), .NWR(NWR), .NRD(NRD), .ZERO_R0(1)) dut (
        .clk(clk), .rst(rst), .wr(wr), .wa(wa), .i(i), .ra(ra), .o(o), .busy(busy)
    );

    logic [WID-1:0]     mdl [DEPTH];
    int                 clr_left = DEPTH;
    logic [NRD*WID-1:0] q_o [$];
    logic               q_b [$];
    int                 n_vec = 0;
    int                 n_err = 0;

    // Predict the effect of the coming rising edge, queue it, then advance.
    task automatic apply();
        logic [NRD*WID-1:0] eo;
        logic               eb;
        logic [AWID-1:0]    a;
        logic [AWID-1:0]    wk;
        logic [WID-1:0]     v;
        eo = '0;
        if (rst) begin
            for (int n = 0; n < DEPTH; n++) mdl[n] = '0;
            clr_left = DEPTH;
            eb = 1'b1;
        end else if (clr_left > 0) begin
            clr_left--;
            eb = (clr_left > 0);
        end else begin
            for (int j = 0; j < NRD; j++) begin
                a = ra[j*AWID +: AWID];
                v = mdl[a];
                for (int k = 0; k < NWR; k++) begin
                    wk = wa[k*AWID +: AWID];
                    if (wr[k] && wk == a) v = i[k*WID +: WID];
                end
                if (a == 0) v = '0;
                eo[j*WID +: WID] = v;
            end
            for (int k = 0; k < NWR; k++) begin
                wk = wa[k*AWID +: AWID];
                if (wr[k] && wk != 0) mdl[wk] = i[k*WID +: WID];
            end
            eb = 1'b0;
        end
        q_o.push_back(eo);
        q_b.push_back(eb);
        @(negedge clk);
    endtask

    task automatic set_w(input int k, input logic en, input logic [AWID-1:0] addr,
                         input logic [WID-1:0] data);
        wr[k]              = en;
        wa[k*AWID +: AWID] = addr;
        i[k*WID +: WID]    = data;
    endtask

    task automatic set_all_r(input logic [AWID-1:0] addr);
        for (int j = 0; j < NRD; j++) ra[j*AWID +: AWID] = addr;
    endtask

    task automatic idle(input int n);
        wr = '0;
        for (int c = 0; c < n; c++) apply();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        apply();
        rst = 1'b0;
    endtask

    task automatic read_all_addrs();
        wr = '0;
        for (int base = 0; base < DEPTH; base += NRD) begin
            for (int j = 0; j < NRD; j++) ra[j*AWID +: AWID] = AWID'(base + j);
            apply();
        end
    endtask

    // Monitor: one queued expectation per rising edge.
    initial begin
        logic [NRD*WID-1:0] eo;
        logic               eb;
        forever begin
            @(posedge clk);
            #1;
            if (q_o.size() > 0) begin
                eo = q_o.pop_front();
                eb = q_b.pop_front();
                n_vec++;
                if (busy !== eb) begin
                    n_err++;
                    $display("FAIL busy @%0t: got %b expected %b", $time, busy, eb);
                end
                for (int j = 0; j < NRD; j++) begin
                    n_vec++;
                    if (o[j*WID +: WID] !== eo[j*WID +: WID]) begin
                        n_err++;
                        $display("FAIL o[%0d] @%0t: got %h expected %h", j, $time,
                                 o[j*WID +: WID], eo[j*WID +: WID]);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        wr  = '0;
        wa  = '0;
        i   = '0;
        ra  = '0;
        for (int n = 0; n < DEPTH; n++) mdl[n] = '0;

        // Initial clear, fill with garbage, then a one-cycle reset must wipe it.
        pulse_rst();
        idle(DEPTH);
        for (int n = 1; n < DEPTH; n++) begin
            set_w(0, 1'b1, AWID'(n), {$urandom, $urandom});
            set_w(1, (n % 3) == 0, AWID'(n), {$urandom, $urandom});
            ra = {NRD{AWID'(n)}};
            apply();
        end
        pulse_rst();
        idle(DEPTH);
        read_all_addrs();

        // Basic write then broadcast read.
        set_w(0, 1'b1, 6'd5, 64'hDEAD_BEEF_0000_0001);
        set_w(1, 1'b0, 6'd0, '0);
        apply();
        wr = '0;
        set_all_r(6'd5);
        apply();

        // Same-address conflict: port 1 wins, then port 0 alone takes over again.
        set_w(0, 1'b1, 6'd9, 64'h11);
        set_w(1, 1'b1, 6'd9, 64'h22);
        apply();
        wr = '0;
        set_all_r(6'd9);
        apply();
        set_w(0, 1'b1, 6'd9, 64'h33);
        apply();
        wr = '0;
        apply();

        // Bypass on 12 while other ports read 13 (preloaded) and 9.
        set_w(1, 1'b1, 6'd13, 64'h1313);
        apply();
        set_w(1, 1'b0, 6'd0, '0);
        set_w(0, 1'b1, 6'd12, 64'h77);
        for (int j = 0; j < NRD; j++) ra[j*AWID +: AWID] = (j % 3 == 0) ? 6'd12 : (j % 3 == 1) ? 6'd13 : 6'd9;
        apply();
        wr = '0;
        apply();

        // Address 0 is hardwired to zero, both bypassed and afterwards.
        set_w(0, 1'b1, 6'd0, 64'hFF);
        set_w(1, 1'b1, 6'd0, 64'hEE);
        set_all_r(6'd0);
        apply();
        wr = '0;
        apply();

        // Reset mid-sweep restarts the full clear; writes during busy are lost.
        pulse_rst();
        idle(30);
        pulse_rst();
        for (int c = 0; c < DEPTH; c++) begin
            set_w(0, 1'b1, 6'd20, {$urandom, $urandom});
            set_w(1, 1'b1, 6'd21, {$urandom, $urandom});
            set_all_r(6'd20);
            apply();
        end
        wr = '0;
        for (int j = 0; j < NRD; j++) ra[j*AWID +: AWID] = (j % 2 == 0) ? 6'd20 : 6'd21;
        apply();

        // Randomized traffic on a narrow address window to force conflicts and bypass hits.
        for (int c = 0; c < 400; c++) begin
            rst = (c == 200);
            for (int k = 0; k < NWR; k++)
                set_w(k, $urandom_range(0, 2) != 0, AWID'($urandom_range(0, 15)), {$urandom, $urandom});
            for (int j = 0; j < NRD; j++)
                ra[j*AWID +: AWID] = AWID'(($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 15));
            apply();
        end
        rst = 1'b0;
        idle(2);

        @(posedge clk);
        #2;
        n_vec++;
        if (q_o.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q_o.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
